// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial adder: one full-adder cell and a carry flop consume one operand
//   bit per clock, LSB first, trading gate area for WIDTH cycles of latency.
//   Works for unsigned and two's-complement operands alike.
//
// Parameters
//   WIDTH      operand/result width in bits (2..64)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request; sampled only while idle
//   a, b       addends; captured on the accepting edge only
//   busy       high while the operation is running
//   done       one-cycle pulse: sum/carry_out were just updated
//   sum        registered result; holds until the next completion
//   carry_out  carry out of bit WIDTH-1, registered with sum
//   overflow   signed overflow, registered with sum
//              (present only when SERIAL_ADDER_OVF_EN is defined)
//
// Build option
//   SERIAL_ADDER_OVF_EN  adds the overflow port and its flop.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             carry_out,
  output logic             overflow
`else
  output logic             carry_out
`endif
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_c;
  logic [CNT_W-1:0] r_cnt;

  logic             w_s;
  logic             w_c_next;
  logic [WIDTH-1:0] w_res_next;

  // Full-adder cell on the current LSBs of the operand shift registers.
  always_comb begin
    w_s        = r_a[0] ^ r_b[0] ^ r_c;
    w_c_next   = (r_a[0] & r_b[0]) | (r_c & (r_a[0] ^ r_b[0]));
    // Sum bits enter at the MSB and move right; after WIDTH shifts bit 0
    // has reached the LSB.
    w_res_next = {w_s, r_res[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_res     <= '0;
      r_c       <= 1'b0;
      r_cnt     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      overflow  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= S_RUN;
          end
        end

        S_RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_c   <= w_c_next;
          r_res <= w_res_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_CNT) begin
            sum       <= w_res_next;
            carry_out <= w_c_next;
`ifdef SERIAL_ADDER_OVF_EN
            // r_c is the carry into the MSB on this final bit.
            overflow  <= r_c ^ w_c_next;
`endif
            busy      <= 1'b0;
            done      <= 1'b1;
            r_state   <= S_DONE;
          end
        end

        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry_out;
`ifdef SERIAL_ADDER_OVF_EN
  logic         overflow;
`endif

  int n_checks = 0;
  int n_errors = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
`ifdef SERIAL_ADDER_OVF_EN
    .carry_out (carry_out),
    .overflow  (overflow)
`else
    .carry_out (carry_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: an accepted request keeps the unit busy for W
  // cycles, then the result (plain integer addition) appears with a one-cycle
  // done pulse, and one more cycle passes before a new request is taken.
  int           m_left = 0;
  bit           m_done = 1'b0;
  logic [W-1:0] m_sum  = '0;
  logic         m_cout = 1'b0;
  logic         m_ovf  = 1'b0;
  logic [W-1:0] m_pa   = '0;
  logic [W-1:0] m_pb   = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0;
      m_done = 1'b0;
      m_sum  = '0;
      m_cout = 1'b0;
      m_ovf  = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        {m_cout, m_sum} = {1'b0, m_pa} + {1'b0, m_pb};
        m_ovf  = (m_pa[W-1] == m_pb[W-1]) && (m_sum[W-1] != m_pa[W-1]);
        m_done = 1'b1;
      end
    end else if (start) begin
      m_pa   = a;
      m_pb   = b;
      m_left = W;
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, m_left > 0);
    chk("done", done, m_done);
    chk("sum", sum, m_sum);
    chk("carry_out", carry_out, m_cout);
`ifdef SERIAL_ADDER_OVF_EN
    chk("overflow", overflow, m_ovf);
`endif
  end

  // One operation from idle; optionally disturbs start/a/b mid-run and checks
  // that the previous result is still shown.
  task automatic run_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic [W-1:0] es, input logic ec, input logic eo,
                        input bit disturb, input logic [W-1:0] prev);
    bit ok;
    int lat;
    ok  = 1'b0;
    lat = 0;
    @(posedge clk); #1;
    a = ta; b = tb_; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (disturb && i == 3) begin
        chk({nm, "_sum_hold"}, sum, prev);
        a = ~ta; b = 8'hFF; start = 1'b1;
      end
      if (disturb && i == 4) start = 1'b0;
      if (done === 1'b1) begin
        ok  = 1'b1;
        lat = i;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: got no done expected done within 20 cycles", nm);
    end else begin
      chk({nm, "_latency"}, lat, W);
      chk({nm, "_sum"}, sum, es);
      chk({nm, "_cout"}, carry_out, ec);
`ifdef SERIAL_ADDER_OVF_EN
      chk({nm, "_ovf"}, overflow, eo);
`else
      if (eo === 1'bx) $display("unexpected x");
`endif
    end
  endtask

  initial begin
    int done_cyc[$];
    int n_done;

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 8'h00);
    chk("rst_cout", carry_out, 0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst_ovf", overflow, 0);
`endif
    @(posedge clk); #2 rst_n = 1'b1;

    run_op("add_0f_01", 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0, 1'b0, '0);
    run_op("add_ff_01", 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, '0);
    run_op("add_7f_01", 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, '0);
    run_op("ignore",    8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b1, 8'h80);

    // Reset in the middle of an operation.
    @(posedge clk); #1;
    a = 8'hAA; b = 8'h55; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_sum", sum, 8'h00);
    chk("midrst_cout", carry_out, 0);
    @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    chk("midrst_no_done", n_done, 0);
    run_op("after_rst", 8'h3C, 8'h42, 8'h7E, 1'b0, 1'b0, 1'b0, '0);

    // start held continuously: one result every W+2 cycles.
    @(posedge clk); #1;
    a = 8'h80; b = 8'h80; start = 1'b1;
    for (int i = 0; i < 60 && done_cyc.size() < 3; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_cyc.push_back(i);
        if (done_cyc.size() == 1) begin
          chk("b2b_sum", sum, 8'h00);
          chk("b2b_cout", carry_out, 1'b1);
        end
      end
    end
    start = 1'b0;
    chk("b2b_count", done_cyc.size(), 3);
    if (done_cyc.size() == 3) begin
      chk("b2b_gap1", done_cyc[1] - done_cyc[0], W + 2);
      chk("b2b_gap2", done_cyc[2] - done_cyc[1], W + 2);
    end
    repeat (W + 4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
